// File: rtl/sad_pkg.sv
// sad_pkg: shared state type, width helper and default
// block geometry for the SAD control and datapath slice.
package sad_pkg;

    // Default block geometry, shared with the datapath
    localparam int N_SAMPLES_DEF = 64;
    localparam int P_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        LOAD,
        DONE
    } sad_state_t;

    // Address width for a beat count; never narrower than one bit
    function automatic int addr_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/sad_beat_counter.sv
// sad_beat_counter: beat address counter for one SAD block.
// Wraps to zero on the final accepted beat.
module sad_beat_counter #(
    parameter int ADDR_W = 4,
    parameter int BEATS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);

    assign last = inc && (count == LAST_BEAT);

    // Count accepted beats; the final beat returns the count to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || last) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sad_ctrl_param.sv
// sad_ctrl_param: sequences one SAD block through a memory
// with one-cycle read latency; all strobes are registered.
module sad_ctrl_param
    import sad_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int P = P_DEF,
    parameter int CNT_W = 16,
    localparam int BEATS = N_SAMPLES / P,
    localparam int ADDR_W = addr_w(N_SAMPLES / P)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              mem_ready,
    input  logic              ack,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic              clr_sum,
    output logic              en_sum,
    output logic              ld_result,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_count
);

    if ((N_SAMPLES % P) != 0 || (N_SAMPLES / P) < 2) begin : g_bad_geometry
        $error("sad_ctrl_param: N_SAMPLES must be a multiple of P with at least two beats");
    end

    sad_state_t state;
    sad_state_t state_nxt;

    logic accepted;
    logic last_beat;

    // rd_en is high exactly while in RUN, so it qualifies acceptance
    assign accepted = rd_en && mem_ready;

    sad_beat_counter #(
        .ADDR_W (ADDR_W),
        .BEATS  (BEATS)
    ) u_beat (
        .clk   (clk),
        .rst   (rst),
        .clear (state == CLR),
        .inc   (accepted),
        .count (addr),
        .last  (last_beat)
    );

    // Next-state decode; inputs outside their owning state are ignored
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = LOAD;
            LOAD:    state_nxt = DONE;
            DONE:    if (ack) state_nxt = mode ? CLR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, registered Moore strobes, en_sum delay and block counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            clr_sum   <= 1'b1;
            en_sum    <= 1'b0;
            ld_result <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            blk_count <= '0;
        end else begin
            state     <= state_nxt;
            rd_en     <= (state_nxt == RUN);
            clr_sum   <= (state_nxt == IDLE) || (state_nxt == CLR);
            en_sum    <= accepted;
            ld_result <= (state_nxt == LOAD);
            done      <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (state == LOAD) begin
                blk_count <= blk_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sad_ctrl_param.sv
// tb_sad_ctrl_param: directed and randomized checks of the
// SAD control unit against a cycle-count reference model.
module tb_sad_ctrl_param;

    localparam int BEATS = 16;

    logic        clk;
    logic        rst;
    logic        start, mode, mem_ready, ack;
    logic [3:0]  addr;
    logic        rd_en, clr_sum, en_sum, ld_result, done, busy;
    logic [15:0] blk_count;

    logic        start2, mode2, mr2, ack2;
    logic [0:0]  addr2;
    logic        rd_en2, clr2, en2, ld2, done2, busy2;
    logic [1:0]  blk_count2;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    sad_ctrl_param #(
        .N_SAMPLES (64),
        .P         (4),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .mem_ready (mem_ready),
        .ack       (ack),
        .addr      (addr),
        .rd_en     (rd_en),
        .clr_sum   (clr_sum),
        .en_sum    (en_sum),
        .ld_result (ld_result),
        .done      (done),
        .busy      (busy),
        .blk_count (blk_count)
    );

    sad_ctrl_param #(
        .N_SAMPLES (64),
        .P         (32),
        .CNT_W     (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .mode      (mode2),
        .mem_ready (mr2),
        .ack       (ack2),
        .addr      (addr2),
        .rd_en     (rd_en2),
        .clr_sum   (clr2),
        .en_sum    (en2),
        .ld_result (ld2),
        .done      (done2),
        .busy      (busy2),
        .blk_count (blk_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from its CLR cycle (cycle 1) until done is seen.
    // exp_d <= 0 means: expected done cycle = BEATS + 4 + stall cycles.
    task automatic blk(input int stall_pct, input bit directed,
                       input bit noise, input int exp_d);
        int cyc, nb, stalls, en_cnt, ld_cyc, dn_cyc, held, want;
        bit acc_prev, mr;
        cyc = 1; nb = 0; stalls = 0; en_cnt = 0;
        ld_cyc = 0; dn_cyc = 0; held = 0; acc_prev = 1'b0;
        chk("clr_cycle_clr", clr_sum, 1);
        chk("clr_cycle_rd", rd_en, 0);
        chk("clr_cycle_busy", busy, 1);
        while (dn_cyc == 0 && cyc < 400) begin
            chk("en_sum", en_sum, acc_prev);
            if (en_sum) en_cnt++;
            chk("addr_range", addr <= 4'(BEATS - 1), 1);
            if (ld_result) ld_cyc = cyc;
            if (done) begin
                dn_cyc = cyc;
            end else begin
                if (cyc >= 2 && nb < BEATS) begin
                    chk("run_rd", rd_en, 1);
                    chk("run_addr", addr, nb);
                    chk("run_clr", clr_sum, 0);
                    if (directed)
                        mr = !((nb == 3 || nb == 7) && held < 2);
                    else
                        mr = ($urandom_range(99) >= stall_pct);
                    if (mr) begin nb++; held = 0; end
                    else begin stalls++; held++; end
                    acc_prev = mr;
                end else begin
                    if (cyc >= 2) chk("tail_rd", rd_en, 0);
                    mr = noise ? 1'($urandom_range(1)) : 1'b0;
                    acc_prev = 1'b0;
                end
                mem_ready = mr;
                if (noise) begin
                    start = 1'($urandom_range(1));
                    ack = 1'($urandom_range(1));
                end
                step();
                cyc++;
            end
        end
        start = 0; ack = 0; mem_ready = 0;
        want = (exp_d > 0) ? exp_d : BEATS + 4 + stalls;
        chk("en_count", en_cnt, BEATS);
        chk("ld_cycle", ld_cyc, want - 1);
        chk("done_cycle", dn_cyc, want);
        exp_cnt++;
    endtask

    // Holds in DONE for hold cycles, then acks with the given mode.
    task automatic ack_done(input bit m, input int hold, input bit with_start);
        chk("blk_count", blk_count, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            chk("done_hold", done, 1);
            start = with_start;
            step();
            start = 0;
        end
        chk("done_before_ack", done, 1);
        ack = 1; mode = m; start = with_start;
        step();
        ack = 0; start = 0;
        chk("done_drop", done, 0);
        chk("busy_after_ack", busy, m);
        chk("clr_after_ack", clr_sum, 1);
    endtask

    initial begin
        rst = 0; start = 0; mode = 0; mem_ready = 0; ack = 0;
        start2 = 0; mode2 = 0; mr2 = 0; ack2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clr", clr_sum, 1);
        chk("rst_rd", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", blk_count, 0);
        chk("rst_cnt2", blk_count2, 0);
        rst = 1;
        step();
        chk("idle_busy", busy, 0);

        // single block, no stalls
        start = 1; step(); start = 0;
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b0, 2, 1'b0);

        // back-pressure on beats 3 and 7
        start = 1; step(); start = 0;
        blk(0, 1'b1, 1'b0, 24);
        ack_done(1'b0, 0, 1'b0);

        // ignored inputs
        start = 1; step(); start = 0;
        blk(0, 1'b0, 1'b1, 20);
        ack_done(1'b0, 2, 1'b1);

        // continuous mode, three blocks without start
        start = 1; step(); start = 0;
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b1, 1, 1'b0);
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b1, 1, 1'b0);
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b0, 1, 1'b0);

        // random stalls and noise
        for (int k = 0; k < 3; k++) begin
            start = 1; step(); start = 0;
            blk(30, 1'b0, 1'b1, 0);
            ack_done(1'b0, $urandom_range(3), 1'b1);
        end

        // simultaneous start and ack: ack wins
        start = 1; step(); start = 0;
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b0, 0, 1'b1);
        step();
        chk("stay_idle", busy, 0);

        // reset mid-RUN at addr 9
        start = 1; step(); start = 0;
        mem_ready = 1;
        for (int i = 0; i < 40 && !(rd_en && addr == 4'd9); i++) step();
        chk("reached_addr9", addr, 9);
        #2;
        rst = 0;
        #1;
        chk("mid_rst_clr", clr_sum, 1);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_rd", rd_en, 0);
        chk("mid_rst_en", en_sum, 0);
        chk("mid_rst_ld", ld_result, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", blk_count, 0);
        mem_ready = 0;
        step();
        rst = 1;
        exp_cnt = 0;
        step();
        start = 1; step(); start = 0;
        blk(0, 1'b0, 1'b0, 20);
        ack_done(1'b0, 1, 1'b0);

        // two-beat corner and 2-bit counter wrap
        mr2 = 1;
        start2 = 1; step(); start2 = 0;
        for (int k = 0; k < 5; k++) begin
            int cyc;
            cyc = 1;
            chk("b2_clr", clr2, 1);
            while (!done2 && cyc < 30) begin
                if (cyc == 2 || cyc == 3) begin
                    chk("b2_rd", rd_en2, 1);
                    chk("b2_addr", addr2, cyc - 2);
                end
                chk("b2_en", en2, (cyc == 3 || cyc == 4));
                chk("b2_ld", ld2, (cyc == 5));
                step();
                cyc++;
            end
            chk("b2_done_cyc", cyc, 6);
            chk("b2_blk_count", blk_count2, (k + 1) % 4);
            ack2 = 1; mode2 = (k < 4);
            step();
            ack2 = 0;
        end
        chk("b2_idle", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sad_ctrl_param.md
# sad_ctrl_param

Parametrised control unit for the SAD partial-sum engine. It sequences one block of `N_SAMPLES` samples, read `P` samples per beat, through a memory with one-cycle read latency. It generates the addresses itself, handles memory back-pressure, and drives the accumulator clear, enable and result-load strobes. A done/ack handshake and an optional continuous mode re-arm the block without a new `start`.

## Interface
Parameters:
- `N_SAMPLES`, default 64: samples per SAD block.
- `P`, default 4: samples consumed per beat (datapath parallelism).
- `CNT_W`, default 16: width of the completed-block counter.
- Derived localparam `BEATS = N_SAMPLES/P`.
- Derived localparam `ADDR_W = max(1, $clog2(BEATS))`.
- Elaboration error unless `N_SAMPLES % P == 0` and `BEATS >= 2`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `start` in 1: request one block; sampled only in IDLE.
- `mode` in 1: 0 = single block, 1 = continuous; sampled when `ack` is accepted.
- `mem_ready` in 1: memory accepts the read this cycle.
- `ack` in 1: acknowledges `done`; sampled only in DONE.
- `addr` out ADDR_W: beat address presented to memory.
- `rd_en` out 1: read request.
- `clr_sum` out 1: zero the accumulator.
- `en_sum` out 1: accumulate the memory data returned this cycle.
- `ld_result` out 1: register the final SAD.
- `done` out 1: result valid, held until `ack`.
- `busy` out 1: high in every state except IDLE.
- `blk_count` out CNT_W: number of completed blocks, wraps modulo 2^CNT_W.

## Operation
States: IDLE, CLR, RUN, DRAIN, LOAD, DONE. Outputs are registered or Moore-decoded from the state and are glitch-free.

- **IDLE:** `clr_sum`=1; all other strobes are 0. On `start` → CLR.
- **CLR:** `clr_sum`=1 for exactly one cycle; the beat counter is zeroed. Next state is RUN unconditionally.
- **RUN:**
  - `rd_en`=1 and `addr`=beat counter.
  - A read is accepted when `rd_en && mem_ready`; the counter increments only on acceptance.
  - When the accepted beat is `BEATS-1` → DRAIN. Otherwise stay in RUN.
  - With `mem_ready`=0, `addr` holds and `rd_en` stays 1.
- **en_sum:** a flop copies "read accepted" with a one-cycle delay. `en_sum` is therefore high in the cycle after each accepted read, in RUN or DRAIN, and is asserted exactly `BEATS` times per block.
- **DRAIN:** `rd_en`=0. This cycle carries the final `en_sum`. Next state is LOAD.
- **LOAD:** `ld_result`=1 for one cycle; `blk_count` increments. Next state is DONE.
- **DONE:** `done`=1. On `ack`:
  - `mode`=1 → CLR (the next block starts with no `start`).
  - `mode`=0 → IDLE.
  - Without `ack`, stay in DONE indefinitely.
- **Ignored inputs:** `start` outside IDLE; `ack` outside DONE; `mem_ready` outside RUN.
- **Simultaneous `start` and `ack` in DONE:** only `ack` acts.

## Timing
- **Reset values** (asynchronous, on `rst`=0):
  - state = IDLE.
  - `clr_sum`=1.
  - `addr`, `rd_en`, `en_sum`, `ld_result`, `done`, `busy` = 0.
  - `blk_count`=0; internal `en_sum` delay flop cleared.
- **Reset mid-operation:** every output returns immediately to its reset value. No partial `ld_result` and no `blk_count` increment.
- **Latency:** `start` sampled at edge 0 → CLR in cycle 1 → RUN in cycles 2..BEATS+1 (when `mem_ready` is held high) → DRAIN at BEATS+2 → LOAD at BEATS+3 → `done` at BEATS+4. Each cycle of `mem_ready` low adds one cycle.
- **Handshake:** `ack` sampled high at an edge in DONE drops `done` in the following cycle.
- **Continuous mode:** `clr_sum` pulses in the cycle after `ack`.
- **Counter wrap:** `blk_count` goes from 2^CNT_W−1 to 0 with no flag.
- **Address range:** `addr` never exceeds `BEATS-1`.

## Structure
- **Package `sad_pkg`:**
  - state enum `sad_state_t` (IDLE, CLR, RUN, DRAIN, LOAD, DONE).
  - width helper function for `ADDR_W`.
  - default values for `N_SAMPLES` and `P`, shared with the datapath.
- **Sub-module `sad_beat_counter`:**
  - parameter: ADDR_W.
  - inputs: clear, increment.
  - outputs: count and a `last` flag, true when count == BEATS-1 and an increment is occurring.
- **Top:** FSM, `en_sum` delay flop and `blk_count` register.

## Test plan
- **Single block, no stalls.** N_SAMPLES=64, P=4, `mode`=0, `mem_ready`=1, `start` pulse → `addr` steps 0..15; `en_sum` high for 16 cycles; `ld_result` at cycle 19; `done` at cycle 20; `ack` → IDLE; `blk_count`=1.
- **Back-pressure.** `mem_ready` low on beats 3 and 7 for 2 cycles each → `addr` holds during the stalls; `en_sum` count is still 16; `done` arrives at cycle 24.
- **Continuous mode.** `mode`=1 with `ack` one cycle after each `done`, run for 3 blocks → `clr_sum` pulse after each `ack`; `blk_count`=3; `start` is never re-asserted.
- **Ignored inputs.** `start` pulsed in RUN and DONE, `ack` pulsed in RUN → no state change; `done` timing is identical to the first scenario.
- **Reset mid-RUN.** Assert `rst`=0 at `addr`=9 → outputs reach their reset values immediately. After release, a new `start` gives the full first-scenario sequence with `blk_count` counting from 0.
- **Parameter corner and wrap.** P=32, N_SAMPLES=64 (BEATS=2, ADDR_W=1) → `done` at cycle 6. CNT_W=2 over 5 blocks → `blk_count` reads 1,2,3,0,1.
